dmem_arbiter: RTL

Shares the single data-memory port between the MEM stage of the five-stage pipeline and a DMA/peripheral master (boot loader, UART, display refresh). Sits between the EX/MEM register outputs and the data memory. Arbitrates with CPU priority and a bounded-starvation guarantee for DMA, and drives the pipeline stall that freezes PC through EX/MEM while a CPU access is pending. Latches the winning request, holds the memory handshake until completion, and aborts hung accesses with a watchdog.

---
 rtl/dmem_arb_pkg.sv | 8 +
 rtl/dmem_arbiter.sv | 82 ++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: arbiter states and default sizing shared by the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_CPU_BUSY, ST_DMA_BUSY} arb_state_t;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_MAX_CPU_RUN = 4;
    localparam int DEF_TIMEOUT     = 16;
endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the MEM stage and a DMA master
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_CPU_RUN = DEF_MAX_CPU_RUN,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic [ADDR_W-1:0] ALUOut_MEM,
    input  logic [DATA_W-1:0] rt_MEM,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);
    localparam int RW = $clog2(MAX_CPU_RUN + 1);
    localparam int WW = $clog2(TIMEOUT);
    arb_state_t    state, state_nx;
    logic [RW-1:0] run_cnt;
    logic [WW-1:0] wd_cnt;
    logic          cpu_req, busy, abort, done, grant_cpu, grant_dma;
    always_comb begin
        cpu_req   = MemRead_MEM | MemWrite_MEM;
        busy      = state != ST_IDLE;
        abort     = busy & ~mem_ready & (wd_cnt == WW'(TIMEOUT - 1));
        done      = mem_ready | abort;
        // DMA wins a contested IDLE only once the CPU has used up its run
        grant_dma = ~busy & dma_req & (~cpu_req | (run_cnt == RW'(MAX_CPU_RUN)));
        grant_cpu = ~busy & cpu_req & ~grant_dma;
        state_nx  = grant_cpu ? ST_CPU_BUSY :
                    grant_dma ? ST_DMA_BUSY :
                    (busy & done) ? ST_IDLE : state;
        mem_req   = busy;
        cpu_stall = cpu_req & ~((state == ST_CPU_BUSY) & done);
        cpu_rdata = ((state == ST_CPU_BUSY) & mem_ready) ? mem_rdata : '0;
        dma_ack   = (state == ST_DMA_BUSY) & done;
        dma_rdata = ((state == ST_DMA_BUSY) & mem_ready) ? mem_rdata : '0;
        bus_err   = abort;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            run_cnt   <= '0;
            wd_cnt    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state  <= state_nx;
            wd_cnt <= (grant_cpu | grant_dma) ? '0 : busy ? wd_cnt + 1'b1 : wd_cnt;
            if (grant_dma)
                run_cnt <= '0;
            else if (grant_cpu)
                run_cnt <= ~dma_req ? '0 : (run_cnt == RW'(MAX_CPU_RUN)) ? run_cnt : run_cnt + 1'b1;
            if (grant_cpu) begin
                mem_we    <= MemWrite_MEM;
                mem_addr  <= ALUOut_MEM;
                mem_wdata <= rt_MEM;
            end else if (grant_dma) begin
                mem_we    <= dma_we;
                mem_addr  <= dma_addr;
                mem_wdata <= dma_wdata;
            end
        end
    end
endmodule
